// File: rtl/memaccess_engine_if.sv
// Request, memory and response bus of memaccess_engine.
// The master side is the engine; the slave side is the requester/memory/consumer.
interface memaccess_engine_if #(
  parameter int DW = 16,
  parameter int AW = 16
);
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;

  modport master (
    input  req_valid, req_op, req_addr, req_wdata, mem_ack, mem_rdata, rsp_ready,
    output req_ready, mem_req, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    output req_valid, req_op, req_addr, req_wdata, mem_ack, mem_rdata, rsp_ready,
    input  req_ready, mem_req, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/memaccess_engine.sv
// Single-outstanding memory access engine: READ, READ_INDIRECT (pointer chase)
// and WRITE with a per-phase ack timeout and a held response.
module memaccess_engine #(
  parameter int DW      = 16,
  parameter int AW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  memaccess_engine_if.master bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, INDIRECT, RESP} state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_RIND  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;
  localparam int         MW       = (DW < AW) ? DW : AW;
  localparam logic [7:0] TMO      = 8'(TIMEOUT);

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;
  logic          req_ready;
  logic          accept;
  logic          acked;
  logic [AW-1:0] ind_addr;

  // The pointer read back is truncated or zero-extended to the address width.
  assign ind_addr  = AW'(bus.mem_rdata[MW-1:0]);
  assign req_ready = (state_q == IDLE) && !reset;
  assign accept    = bus.req_valid && req_ready;
  assign acked     = bus.mem_ack && mem_req_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rsp_data_d = '0;
          if (bus.req_op == OP_RSVD) begin
            state_d   = RESP;
            rsp_err_d = 1'b1;
          end else begin
            state_d     = ACCESS;
            op_d        = bus.req_op;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = (bus.req_op == OP_WRITE);
            mem_addr_d  = bus.req_addr;
            mem_wdata_d = bus.req_wdata;
            rsp_err_d   = 1'b0;
          end
        end
      end
      ACCESS, INDIRECT: begin
        // An ack in the same cycle the wait count would expire still wins.
        if (acked) begin
          cnt_d = '0;
          if (state_q == ACCESS && op_q == OP_RIND) begin
            state_d    = INDIRECT;
            mem_addr_d = ind_addr;
          end else begin
            state_d    = RESP;
            mem_req_d  = 1'b0;
            mem_we_d   = 1'b0;
            rsp_err_d  = 1'b0;
            rsp_data_d = (op_q == OP_WRITE) ? '0 : bus.mem_rdata;
          end
        end else if (cnt_q + 8'd1 == TMO) begin
          state_d    = RESP;
          cnt_d      = TMO;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_READ;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_memaccess_engine.sv
// Directed bench for memaccess_engine: a transaction-level timeline model is
// compared against the DUT every cycle, with hand-computed pins per transaction.
module tb_memaccess_engine;

  localparam int TMO  = 15;
  localparam int MAXT = 80;

  logic clock;
  logic reset;

  memaccess_engine_if #(.DW(16), .AW(16)) bus ();

  memaccess_engine #(.DW(16), .AW(16), .TIMEOUT(TMO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] model_mem [int];
  logic [15:0] phys_mem  [int];
  int          delay_q   [$];
  logic        spurious_ack = 1'b0;

  // Expected per-cycle behaviour, indexed by cycles after request acceptance.
  logic        exp_req   [MAXT];
  logic        exp_we    [MAXT];
  logic [15:0] exp_addr  [MAXT];
  logic [15:0] exp_wdata [MAXT];
  logic        exp_rv    [MAXT];
  logic [15:0] exp_data  [MAXT];
  logic        exp_err   [MAXT];
  logic        exp_rdy   [MAXT];
  int          model_rsp_t;
  int          model_ready_t;
  int          model_len;
  logic [15:0] model_data;
  logic        model_err;

  int   t_cur      = 0;
  logic active     = 1'b0;
  logic free_check = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [15:0] modelRead(input logic [15:0] a);
    return model_mem.exists(int'(a)) ? model_mem[int'(a)] : 16'h0000;
  endfunction

  function automatic logic [15:0] physRead(input logic [15:0] a);
    return phys_mem.exists(int'(a)) ? phys_mem[int'(a)] : 16'h0000;
  endfunction

  task automatic preload(input logic [15:0] a, input logic [15:0] v);
    model_mem[int'(a)] = v;
    phys_mem[int'(a)]  = v;
  endtask

  // A phase acks after d idle mem_req cycles; d < 0 or d >= TMO means it times out.
  task automatic buildModel(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wdata,
                            input int d1, input int d2, input int hold);
    bit          t1, t2;
    int          n1, n2;
    logic [15:0] ptr;
    for (int t = 0; t < MAXT; t++) begin
      exp_req[t] = 1'b0; exp_we[t] = 1'b0; exp_addr[t] = '0; exp_wdata[t] = '0;
      exp_rv[t] = 1'b0; exp_data[t] = '0; exp_err[t] = 1'b0; exp_rdy[t] = 1'b0;
    end
    t1 = (d1 < 0) || (d1 >= TMO);
    n1 = t1 ? TMO : d1 + 1;
    model_data = 16'h0000;
    model_err  = 1'b0;
    if (op == 2'b11) begin
      model_rsp_t = 1;
      model_err   = 1'b1;
    end else begin
      for (int t = 1; t <= n1; t++) begin
        exp_req[t] = 1'b1; exp_addr[t] = addr; exp_we[t] = (op == 2'b10); exp_wdata[t] = wdata;
      end
      model_rsp_t = n1 + 1;
      if (t1) begin
        model_err = 1'b1;
      end else if (op == 2'b00) begin
        model_data = modelRead(addr);
      end else if (op == 2'b10) begin
        model_mem[int'(addr)] = wdata;
      end else begin
        ptr = modelRead(addr);
        t2  = (d2 < 0) || (d2 >= TMO);
        n2  = t2 ? TMO : d2 + 1;
        for (int t = n1 + 1; t <= n1 + n2; t++) begin
          exp_req[t] = 1'b1; exp_addr[t] = ptr;
        end
        model_rsp_t = n1 + n2 + 1;
        model_err   = t2;
        model_data  = t2 ? 16'h0000 : modelRead(ptr);
      end
    end
    for (int t = model_rsp_t; t <= model_rsp_t + hold; t++) begin
      exp_rv[t] = 1'b1; exp_data[t] = model_data; exp_err[t] = model_err;
    end
    model_ready_t = model_rsp_t + hold;
    model_len     = model_ready_t + 1;
    exp_rdy[model_len] = 1'b1;
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wdata,
                               input int d1, input int d2, input int hold,
                               input int pin_t, input logic [15:0] pin_data, input logic pin_err);
    buildModel(op, addr, wdata, d1, d2, hold);
    checkOutput("model_rsp_cycle", 32'(model_rsp_t), 32'(pin_t));
    checkOutput("model_rsp_data", 32'(model_data), 32'(pin_data));
    checkOutput("model_rsp_err", 32'(model_err), 32'(pin_err));
    delay_q.delete();
    delay_q.push_back(d1);
    delay_q.push_back(d2);
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 16'hFFFF;
    bus.req_wdata = 16'hFFFF;
    t_cur  = 1;
    active = 1'b1;
    bus.rsp_ready = (t_cur == model_ready_t);
    while (t_cur < model_len) begin
      @(posedge clock); #1;
      t_cur++;
      bus.rsp_ready = (t_cur == model_ready_t);
    end
    @(negedge clock); #1;
    active = 1'b0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  // Memory responder: pops one ack delay per access phase, models a RAM.
  initial begin : responder
    bit in_phase  = 0;
    int wait_cnt  = 0;
    int cur_delay = -1;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'hDEAD;
    forever begin
      @(posedge clock); #1;
      if (reset) begin
        in_phase    = 0;
        bus.mem_ack = 1'b0;
      end else if (!bus.mem_req) begin
        in_phase      = 0;
        bus.mem_ack   = spurious_ack;
        bus.mem_rdata = 16'hBAD0;
      end else begin
        if (!in_phase) begin
          in_phase  = 1;
          wait_cnt  = 0;
          cur_delay = (delay_q.size() > 0) ? delay_q.pop_front() : -1;
        end
        if (wait_cnt == cur_delay) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = physRead(bus.mem_addr);
          if (bus.mem_we) phys_mem[int'(bus.mem_addr)] = bus.mem_wdata;
          in_phase = 0;
        end else begin
          bus.mem_ack   = 1'b0;
          bus.mem_rdata = 16'hDEAD;
          wait_cnt++;
        end
      end
    end
  end

  // Single compare process: model timeline while a transaction runs, idle otherwise.
  always @(negedge clock) begin
    if (active) begin
      checkOutput($sformatf("req_ready@t%0d", t_cur), 32'(bus.req_ready), 32'(exp_rdy[t_cur]));
      checkOutput($sformatf("mem_req@t%0d", t_cur), 32'(bus.mem_req), 32'(exp_req[t_cur]));
      if (exp_req[t_cur]) begin
        checkOutput($sformatf("mem_addr@t%0d", t_cur), 32'(bus.mem_addr), 32'(exp_addr[t_cur]));
        checkOutput($sformatf("mem_we@t%0d", t_cur), 32'(bus.mem_we), 32'(exp_we[t_cur]));
        if (exp_we[t_cur])
          checkOutput($sformatf("mem_wdata@t%0d", t_cur), 32'(bus.mem_wdata), 32'(exp_wdata[t_cur]));
      end
      checkOutput($sformatf("rsp_valid@t%0d", t_cur), 32'(bus.rsp_valid), 32'(exp_rv[t_cur]));
      if (exp_rv[t_cur]) begin
        checkOutput($sformatf("rsp_data@t%0d", t_cur), 32'(bus.rsp_data), 32'(exp_data[t_cur]));
        checkOutput($sformatf("rsp_err@t%0d", t_cur), 32'(bus.rsp_err), 32'(exp_err[t_cur]));
      end
    end else if (free_check) begin
      checkOutput("idle_req_ready", 32'(bus.req_ready), 32'd1);
      checkOutput("idle_mem_req", 32'(bus.mem_req), 32'd0);
      checkOutput("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    checkOutput({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
    checkOutput({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    checkOutput({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    checkOutput({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    checkOutput({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    checkOutput({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'd0);
    checkOutput({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
  endtask

  task automatic resetMidIndirect();
    int   waited  = 0;
    logic reached = 1'b0;
    delay_q.delete();
    delay_q.push_back(0);
    delay_q.push_back(-1);
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b01;
    bus.req_addr  = 16'h3100;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    free_check    = 1'b0;
    while (!reached && waited < 20) begin
      @(negedge clock);
      if (bus.mem_req && bus.mem_addr == 16'h4100) reached = 1'b1;
      waited++;
    end
    checkOutput("reach_indirect", 32'(reached), 32'd1);
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    checkResetOutputs("midrst");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    delay_q.delete();
    #1;
    checkOutput("ready_after_reset", 32'(bus.req_ready), 32'd1);
    free_check = 1'b1;
    repeat (6) @(negedge clock);
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    preload(16'h3000, 16'hBEEF);
    preload(16'h3001, 16'h4000);
    preload(16'h4000, 16'h1234);
    preload(16'h3100, 16'h4100);
    preload(16'h4100, 16'h5555);
    repeat (3) @(negedge clock);
    checkResetOutputs("rst");
    reset = 1'b0;
    #1;
    checkOutput("ready_after_first_reset", 32'(bus.req_ready), 32'd1);
    free_check = 1'b1;
    @(negedge clock);

    $display("[TB] basic read, indirect read, write");
    applyStimulus(2'b00, 16'h3000, 16'h0000,  0,  0, 0,  2, 16'hBEEF, 1'b0);
    applyStimulus(2'b01, 16'h3001, 16'h0000,  0,  0, 0,  3, 16'h1234, 1'b0);
    applyStimulus(2'b01, 16'h3001, 16'h0000,  2,  1, 1,  6, 16'h1234, 1'b0);
    applyStimulus(2'b10, 16'h2000, 16'h00FF,  2,  0, 0,  4, 16'h0000, 1'b0);
    applyStimulus(2'b00, 16'h2000, 16'h0000,  1,  0, 2,  3, 16'h00FF, 1'b0);

    $display("[TB] timeout boundaries");
    applyStimulus(2'b00, 16'h3000, 16'h0000, -1,  0, 0, 16, 16'h0000, 1'b1);
    applyStimulus(2'b00, 16'h3000, 16'h0000, 14,  0, 0, 16, 16'hBEEF, 1'b0);
    applyStimulus(2'b01, 16'h3001, 16'h0000,  0, -1, 0, 17, 16'h0000, 1'b1);
    applyStimulus(2'b10, 16'h2002, 16'hABCD, -1,  0, 0, 16, 16'h0000, 1'b1);
    applyStimulus(2'b00, 16'h2002, 16'h0000,  0,  0, 0,  2, 16'h0000, 1'b0);

    $display("[TB] reserved op with stray acks and held response");
    spurious_ack = 1'b1;
    applyStimulus(2'b11, 16'h3000, 16'h0000,  0,  0, 4,  1, 16'h0000, 1'b1);
    spurious_ack = 1'b0;
    @(negedge clock);

    $display("[TB] reset during indirect phase");
    resetMidIndirect();
    applyStimulus(2'b00, 16'h3000, 16'h0000,  0,  0, 0,  2, 16'hBEEF, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
